seq_divider: RTL

Sequential 8-bit unsigned restoring divider, the inverse-direction companion to the team's combinational add/subtract datapath. It computes one quotient bit per clock with a 9-bit trial subtraction, so an 8-bit divide takes 8 iterations. A start/done handshake lets a controller issue a divide and collect quotient and remainder. It sits next to the adder in the arithmetic unit and handles the divide operation.

---
 rtl/seq_divider_pkg.sv | 11 +
 rtl/div_sub_stage.sv | 25 ++
 rtl/seq_divider.sv | 116 +++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared widths and FSM encoding for the sequential restoring divider.
package seq_divider_pkg;
  localparam int DIV_WIDTH = 8;
  localparam int CNT_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/div_sub_stage.sv
// Ripple trial subtractor: diff = r + ~d + 1 built from full-adder cells.
module div_sub_stage
  import seq_divider_pkg::*;
#(
  parameter int W = DIV_WIDTH + 1
) (
  input  logic [W-1:0] r,
  input  logic [W-1:0] d,
  output logic [W-1:0] diff,
  output logic         no_borrow
);
  logic [W:0]   carry;
  logic [W-1:0] d_inv;

  assign d_inv    = ~d;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign diff[i]    = r[i] ^ d_inv[i] ^ carry[i];
    assign carry[i+1] = (r[i] & d_inv[i]) | (carry[i] & (r[i] ^ d_inv[i]));
  end

  // Carry out of the top cell set means r >= d.
  assign no_borrow = carry[W];
endmodule

// File: rtl/seq_divider.sv
// 8-bit unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Optional SEQ_DIVIDER_ZERO_CHECK_EN: zero divisor short-circuits to DONE and flags div_by_zero.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       fsm_state
);
  // Handshake: start is honoured only at a rising edge where ready=1; a start
  // while busy is dropped. done is a one-cycle pulse and the results then hold
  // until the next accepted start.
  state_e               state;
  logic [WIDTH-1:0]     r_q;
  logic [WIDTH-1:0]     q_q;
  logic [WIDTH-1:0]     d_q;
  logic [CNT_WIDTH-1:0] cnt;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_diff;
  logic             no_borrow;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             zero_fast;
  logic             accept;
  logic             unused_diff_msb;

  assign r_shift = {1'b0, r_q, q_q[WIDTH-1]};

  div_sub_stage #(.W(WIDTH + 1)) u_sub (
    .r         (r_shift),
    .d         ({1'b0, d_q}),
    .diff      (r_diff),
    .no_borrow (no_borrow)
  );

  // A restored or accepted partial remainder is always below D, so bit WIDTH is zero.
  assign r_next          = no_borrow ? r_diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
  assign q_next          = {q_q[WIDTH-2:0], no_borrow};
  assign unused_diff_msb = r_diff[WIDTH];

  assign ready     = (state == ST_IDLE) || (state == ST_DONE);
  assign busy      = (state == ST_CALC);
  assign done      = (state == ST_DONE);
  assign fsm_state = state;
  assign accept    = ready && start;

`ifdef SEQ_DIVIDER_ZERO_CHECK_EN
  assign zero_fast = (divisor == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_by_zero <= 1'b0;
    end else if (accept) begin
      div_by_zero <= (divisor == '0);
    end
  end
`else
  assign zero_fast   = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            d_q <= divisor;
            r_q <= '0;
            q_q <= dividend;
            cnt <= '0;
            if (zero_fast) begin
              state     <= ST_DONE;
              quotient  <= '1;
              remainder <= dividend;
            end else begin
              state <= ST_CALC;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          r_q <= r_next;
          q_q <= q_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_WIDTH'(WIDTH - 1)) begin
            state     <= ST_DONE;
            quotient  <= q_next;
            remainder <= r_next;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
